divider_16bit_seq: RTL and testbench

- Sequential fixed-point divider. It is the inverse operator to the 16-bit fixed-point multiplier in the ODE solver datapath, and computes first_operand / second_operand.
- Uses the same 16-bit scaled format as the multiplier: bits [15:13] are an unsigned scale factor S, and bits [12:0] are a two's-complement number N. The encoded value is N / 2^S.
- Iterative restoring division, one quotient bit per clock, with a start/busy/done handshake. The solver controller issues one division and waits for done.

---
 rtl/fixed_point_pkg.sv | 33 +++
 rtl/fixed_point_unpack.sv | 21 ++
 rtl/divider_16bit_seq.sv | 209 ++++++++++++++++++++
 tb/tb_divider_16bit_seq.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/fixed_point_pkg.sv
// Shared definitions for the scaled 16-bit fixed-point format (scale S in the top bits, two's-complement N below).
package fixed_point_pkg;

   localparam int unsigned WORD_W  = 16;
   localparam int unsigned SCALE_W = 3;
   localparam int unsigned NUM_W   = WORD_W - SCALE_W;
   // One extra bit so that the magnitude of the most negative number is representable.
   localparam int unsigned SNUM_W  = NUM_W + 1;

   localparam logic [NUM_W-1:0] FIX_MAX = 13'h0FFF;
   localparam logic [NUM_W-1:0] FIX_MIN = 13'h1000;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      DIVIDE = 2'd2,
      FINISH = 2'd3
   } div_state_e;

   typedef struct packed {
      logic [SCALE_W-1:0]       scale;
      logic signed [SNUM_W-1:0] num;
   } fix_unpacked_t;

   // Split a scaled word into its scale field and its sign-extended number field.
   function automatic fix_unpacked_t fix_unpack(input logic [WORD_W-1:0] word);
      fix_unpacked_t r;
      r.scale = word[WORD_W-1:NUM_W];
      r.num   = {{(SNUM_W-NUM_W){word[NUM_W-1]}}, word[NUM_W-1:0]};
      return r;
   endfunction

endpackage

// File: rtl/fixed_point_unpack.sv
// Combinational operand decode: scale field, sign, and unsigned magnitude of the number field.
module fixed_point_unpack
   import fixed_point_pkg::*;
(
   input  logic [WORD_W-1:0]  word,
   output logic [SCALE_W-1:0] scale_c,
   output logic               neg_c,
   output logic [NUM_W-1:0]   mag_c
);

   fix_unpacked_t fields;

   // Field split and absolute value; |-4096| = 4096 still fits the 13-bit unsigned magnitude.
   always_comb begin
      fields  = fix_unpack(word);
      scale_c = fields.scale;
      neg_c   = fields.num[SNUM_W-1];
      mag_c   = NUM_W'(neg_c ? -fields.num : fields.num);
   end

endmodule

// File: rtl/divider_16bit_seq.sv
// Sequential restoring divider for the scaled fixed-point format: one quotient bit per clock.
module divider_16bit_seq #(
   parameter int unsigned WORD_W  = 16,
   parameter int unsigned SCALE_W = 3,
   parameter int unsigned DIV_W   = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [WORD_W-1:0] first_operand,
   input  logic [WORD_W-1:0] second_operand,
   output logic              busy,
   output logic              done,
   output logic [WORD_W-1:0] out,
   output logic              overflow
);

   import fixed_point_pkg::*;

   localparam int unsigned N_W   = WORD_W - SCALE_W;
   localparam int unsigned REM_W = N_W + 1;
   localparam int unsigned SH_W  = SCALE_W + 1;
   localparam int unsigned CNT_W = $clog2(DIV_W);

   // Operand decode
   logic [SCALE_W-1:0] scale_a_c, scale_b_c;
   logic               neg_a_c, neg_b_c;
   logic [N_W-1:0]     mag_a_c, mag_b_c;

   fixed_point_unpack u_unpack_a (
      .word    (first_operand),
      .scale_c (scale_a_c),
      .neg_c   (neg_a_c),
      .mag_c   (mag_a_c)
   );

   fixed_point_unpack u_unpack_b (
      .word    (second_operand),
      .scale_c (scale_b_c),
      .neg_c   (neg_b_c),
      .mag_c   (mag_b_c)
   );

   // FSM and registered outputs
   div_state_e state, state_nx;
   logic       busy_nx, done_nx, overflow_nx;
   logic [WORD_W-1:0] out_nx;
   logic       capture_c, load_c, step_c;

   // Captured operand information
   logic [SCALE_W-1:0] so_q;
   logic [SH_W-1:0]    k_q;
   logic [N_W-1:0]     mag_a_q, mag_b_q;
   logic               sign_a_q, neg_q;

   // Division datapath
   logic [DIV_W-1:0]   dividend_q;
   logic [N_W-1:0]     divisor_q;
   logic [N_W-1:0]     rem_q;
   logic               div0_q;
   logic [CNT_W-1:0]   cnt_q;

   logic [SCALE_W-1:0] so_c;
   logic [SH_W-1:0]    k_c;
   logic [REM_W-1:0]   rem_sh_c;
   logic               ge_c;
   logic [N_W-1:0]     rem_nx_c;
   logic [N_W-1:0]     q_lo_c;
   logic [N_W-1:0]     res_num_c;
   logic               res_ovf_c;

   // Output scale is the larger input scale; the numerator pre-shift aligns the quotient to it.
   always_comb begin
      so_c = (scale_a_c > scale_b_c) ? scale_a_c : scale_b_c;
      k_c  = SH_W'(so_c) - SH_W'(scale_a_c) + SH_W'(scale_b_c);
   end

   // One restoring step: shift {rem, dividend} left, trial-subtract, keep or restore.
   always_comb begin
      rem_sh_c = {rem_q, dividend_q[DIV_W-1]};
      ge_c     = (rem_sh_c >= {1'b0, divisor_q});
      rem_nx_c = ge_c ? N_W'(rem_sh_c - {1'b0, divisor_q}) : N_W'(rem_sh_c);
   end

   // Sign application and saturation of the final quotient.
   always_comb begin
      res_num_c = '0;
      res_ovf_c = 1'b0;
      q_lo_c    = dividend_q[N_W-1:0];
      if (div0_q) begin
         res_ovf_c = 1'b1;
         res_num_c = sign_a_q ? N_W'(FIX_MIN) : N_W'(FIX_MAX);
      end else if (dividend_q == '0) begin
         res_num_c = '0;
      end else if (!neg_q) begin
         if (dividend_q <= DIV_W'(FIX_MAX)) begin
            res_num_c = q_lo_c;
         end else begin
            res_ovf_c = 1'b1;
            res_num_c = N_W'(FIX_MAX);
         end
      end else begin
         if (dividend_q <= DIV_W'(FIX_MIN)) begin
            res_num_c = (~q_lo_c) + N_W'(1);
         end else begin
            res_ovf_c = 1'b1;
            res_num_c = N_W'(FIX_MIN);
         end
      end
   end

   // Next-state and output decode.
   always_comb begin
      state_nx    = state;
      busy_nx     = busy;
      done_nx     = 1'b0;
      out_nx      = out;
      overflow_nx = overflow;
      capture_c   = 1'b0;
      load_c      = 1'b0;
      step_c      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nx  = SETUP;
               busy_nx   = 1'b1;
               capture_c = 1'b1;
            end
         end
         SETUP: begin
            state_nx = DIVIDE;
            load_c   = 1'b1;
         end
         DIVIDE: begin
            step_c = 1'b1;
            if (cnt_q == '0) begin
               state_nx = FINISH;
            end
         end
         FINISH: begin
            state_nx    = IDLE;
            busy_nx     = 1'b0;
            done_nx     = 1'b1;
            out_nx      = {so_q, res_num_c};
            overflow_nx = res_ovf_c;
         end
         default: begin
            state_nx = IDLE;
            busy_nx  = 1'b0;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         out      <= '0;
         overflow <= 1'b0;
      end else begin
         state    <= state_nx;
         busy     <= busy_nx;
         done     <= done_nx;
         out      <= out_nx;
         overflow <= overflow_nx;
      end
   end

   // Operand capture, setup load and per-cycle division step.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         so_q       <= '0;
         k_q        <= '0;
         mag_a_q    <= '0;
         mag_b_q    <= '0;
         sign_a_q   <= 1'b0;
         neg_q      <= 1'b0;
         dividend_q <= '0;
         divisor_q  <= '0;
         rem_q      <= '0;
         div0_q     <= 1'b0;
         cnt_q      <= '0;
      end else begin
         if (capture_c) begin
            so_q     <= so_c;
            k_q      <= k_c;
            mag_a_q  <= mag_a_c;
            mag_b_q  <= mag_b_c;
            sign_a_q <= neg_a_c;
            neg_q    <= neg_a_c ^ neg_b_c;
         end
         if (load_c) begin
            dividend_q <= DIV_W'(mag_a_q) << k_q;
            divisor_q  <= mag_b_q;
            rem_q      <= '0;
            div0_q     <= (mag_b_q == '0);
            cnt_q      <= CNT_W'(DIV_W - 1);
         end
         if (step_c) begin
            dividend_q <= {dividend_q[DIV_W-2:0], ge_c};
            rem_q      <= rem_nx_c;
            cnt_q      <= cnt_q - CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_divider_16bit_seq.sv
// Scoreboard bench for divider_16bit_seq: driver pushes expected results, monitor checks on done.
module tb_divider_16bit_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [15:0] first_operand;
   logic [15:0] second_operand;
   logic        busy;
   logic        done;
   logic [15:0] out;
   logic        overflow;

   divider_16bit_seq dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .first_operand  (first_operand),
      .second_operand (second_operand),
      .busy           (busy),
      .done           (done),
      .out            (out),
      .overflow       (overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] q;
      logic        ovf;
      int unsigned due;
   } exp_t;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] q;
      logic        ovf;
   } vec_t;

   exp_t        sb_q[$];
   int unsigned cyc = 0;
   int          n_tests = 0;
   int          n_fail = 0;

   localparam int unsigned LAT = 35;  // negedge count from issue to done-visible (34 clocks after the sampling edge)

   vec_t vecs[11] = '{
      '{16'h0006, 16'h0004, 16'h0001, 1'b0},  // 6/4 -> 1 (truncated)
      '{16'h2003, 16'h2001, 16'h2006, 1'b0},  // 1.5/0.5 -> 3.0
      '{16'h1FFA, 16'h0004, 16'h1FFF, 1'b0},  // -6/4 -> -1
      '{16'h0FFF, 16'h6001, 16'h6FFF, 1'b1},  // 4095/(1/8) saturates
      '{16'h1000, 16'h0001, 16'h1000, 1'b0},  // -4096 fits
      '{16'h0005, 16'h0000, 16'h0FFF, 1'b1},  // +x/0
      '{16'h1FFB, 16'h0000, 16'h1000, 1'b1},  // -x/0
      '{16'h1FFF, 16'h0004, 16'h0000, 1'b0},  // -1/4 -> zero, no negative zero
      '{16'h0003, 16'h2001, 16'h200C, 1'b0},  // 3/0.5 -> 6.0 at scale 1
      '{16'h1000, 16'h1FFF, 16'h0FFF, 1'b1},  // -4096/-1 = +4096 overflows
      '{16'h4005, 16'h0000, 16'h4FFF, 1'b1}   // div0 keeps output scale
   };

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every done must match the oldest outstanding expectation, at the exact cycle.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && done === 1'b1) begin
         if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_done: out=%h overflow=%b at cycle %0d", out, overflow, cyc);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("out", 32'(out), 32'(e.q));
            chk("overflow", 32'(overflow), 32'(e.ovf));
            chk("done_cycle", 32'(cyc), 32'(e.due));
         end
      end
   end

   task automatic issue(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] q, input logic ovf, input bit expect_done);
      first_operand  = a;
      second_operand = b;
      start          = 1'b1;
      if (expect_done) sb_q.push_back('{q: q, ovf: ovf, due: cyc + LAT});
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_start", 32'(busy), 32'd1);
   endtask

   task automatic wait_done();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      chk("done_seen", 32'(seen), 32'd1);
      if (seen) chk("busy_at_done", 32'(busy), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n          = 1'b0;
      start          = 1'b0;
      first_operand  = '0;
      second_operand = '0;
      repeat (3) @(negedge clk);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      chk("reset_out", 32'(out), 32'd0);
      chk("reset_overflow", 32'(overflow), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed vectors
      foreach (vecs[i]) begin
         issue(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].ovf, 1'b1);
         wait_done();
         repeat (2) @(negedge clk);
      end

      // start re-pulsed mid-operation must be ignored
      issue(16'h0006, 16'h0004, 16'h0001, 1'b0, 1'b1);
      repeat (9) @(negedge clk);
      first_operand  = 16'h0005;
      second_operand = 16'h0000;
      start          = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_during_repulse", 32'(busy), 32'd1);
      wait_done();
      repeat (40) @(negedge clk);

      // reset mid-operation aborts with no done
      issue(16'h2003, 16'h2001, 16'h2006, 1'b0, 1'b0);
      repeat (19) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_out", 32'(out), 32'd0);
      chk("abort_overflow", 32'(overflow), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);

      // back-to-back: new start on the done cycle
      issue(16'h0FFF, 16'h6001, 16'h6FFF, 1'b1, 1'b1);
      wait_done();
      issue(16'h1000, 16'h0001, 16'h1000, 1'b0, 1'b1);
      wait_done();
      repeat (5) @(negedge clk);

      chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
